// File: rtl/core_seq_ctrl_pkg.sv
// rtl/core_seq_ctrl_pkg.sv - shared state encodings and defaults for the core sequencer
//
// Purpose: one place for the sequencer state encoding so trace/difftest logic
// decodes state_dbg the same way the FSM drives it.
// Contents: STATE_W, state_e (S_IDLE..S_ERR), default watchdog width/limit.
package core_seq_ctrl_pkg;

  localparam int STATE_W     = 3;
  localparam int TMO_W_DEF   = 8;
  localparam int TMO_MAX_DEF = 255;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/core_seq_ctrl_watchdog.sv
// rtl/core_seq_ctrl_watchdog.sv - handshake watchdog counter for the core sequencer
//
// Purpose: counts cycles spent waiting on a fetch or memory response.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       force count to 0 (has priority over en)
//   en        increment count this cycle
//   expired   count has reached TMO_MAX
module core_seq_ctrl_watchdog #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TMO_MAX);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - multi-cycle fetch/exec/mem/writeback sequencer for the single-issue core
//
// Purpose: steps one instruction at a time through FETCH, EXEC, optional MEM and WB,
// with a watchdog on the fetch and memory handshakes, sticky halt on ebreak and
// sticky bus error on watchdog expiry.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   ifu_req        fetch request, high throughout FETCH
//   ifu_rvalid     fetch data valid (honoured only in FETCH)
//   inst_latch_en  instruction capture pulse, cycle ifu_rvalid is accepted
//   dec_mem        decoded load/store (sampled in EXEC)
//   dec_rf_wen     decoded rd write (sampled in WB)
//   dec_ebreak     decoded ebreak (sampled in EXEC)
//   lsu_req        memory request, high throughout MEM
//   lsu_done       memory completion (honoured only in MEM)
//   rf_wen         register-file write strobe
//   pc_update_en   PC advance strobe, one cycle per retired instruction
//   halted         sticky, ebreak retired
//   bus_err        sticky, watchdog expired
//   state_dbg      current state encoding
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int TMO_W   = TMO_W_DEF,
  parameter int TMO_MAX = TMO_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ifu_req,
  input  logic               ifu_rvalid,
  output logic               inst_latch_en,
  input  logic               dec_mem,
  input  logic               dec_rf_wen,
  input  logic               dec_ebreak,
  output logic               lsu_req,
  input  logic               lsu_done,
  output logic               rf_wen,
  output logic               pc_update_en,
  output logic               halted,
  output logic               bus_err,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state;
  state_e nxt;
  logic   wd_clr;
  logic   wd_en;
  logic   wd_exp;

  // Every path into FETCH or MEM comes from a state that is neither, so holding
  // the counter cleared outside those two states gives a fresh count on entry.
  assign wd_clr = (state != S_FETCH) && (state != S_MEM);
  assign wd_en  = ((state == S_FETCH) && !ifu_rvalid) ||
                  ((state == S_MEM)   && !lsu_done);

  core_seq_ctrl_watchdog #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_exp)
  );

  // A response in the same cycle as expiry wins: it is tested first.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = S_FETCH;
      S_FETCH: begin
        if (ifu_rvalid)  nxt = S_EXEC;
        else if (wd_exp) nxt = S_ERR;
      end
      S_EXEC: begin
        if (dec_ebreak)   nxt = S_HALT;
        else if (dec_mem) nxt = S_MEM;
        else              nxt = S_WB;
      end
      S_MEM: begin
        if (lsu_done)    nxt = S_WB;
        else if (wd_exp) nxt = S_ERR;
      end
      S_WB:    nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      S_ERR:   nxt = S_ERR;
      default: nxt = S_IDLE;
    endcase
  end

  // Level outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      ifu_req <= 1'b0;
      lsu_req <= 1'b0;
      halted  <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state   <= nxt;
      ifu_req <= (nxt == S_FETCH);
      lsu_req <= (nxt == S_MEM);
      halted  <= (nxt == S_HALT);
      bus_err <= (nxt == S_ERR);
    end
  end

  // Strobes are decoded from the current state so they fire in the accepting cycle.
  assign inst_latch_en = (state == S_FETCH) && ifu_rvalid;
  assign pc_update_en  = (state == S_WB);
  assign rf_wen        = (state == S_WB) && dec_rf_wen;
  assign state_dbg     = state;

endmodule
